bus_arbiter2: RTL and testbench
===============================

// Module: bus_arbiter2
// PURPOSE
//  Two-master arbiter that shares the single CPU memory bus between master 0 (CPU core bus port) and master 1 (loader/debug/DMA).
//  - Grants one master at a time, round-robin.
//  - Muxes the owner's request onto the slave side and routes the slave's handshakes back to the owner only.
//  - Sits between the masters and the memory/peripheral bus slave.
// PARAMETERS
//  ADDR_W          32   address width
//  DATA_W          32   data width
//  TIMEOUT_CYCLES  256  watchdog limit, in cycles; used only with BUS_ARB_TIMEOUT_EN
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       synchronous reset, active-high
//  mN_valid    in   1       master N request (N=0,1); held until completion
//  mN_mode     in   1       master N direction: 1 = write, 0 = read
//  mN_addr     in   ADDR_W  master N address
//  mN_wdata    in   DATA_W  master N write data
//  mN_rready   in   1       master N ready to accept read data
//  mN_wready   out  1       write-complete pulse to master N
//  mN_rvalid   out  1       read-data-valid to master N
//  mN_rdata    out  DATA_W  read data to master N
//  s_valid     out  1       request to slave
//  s_mode      out  1       direction to slave
//  s_addr      out  ADDR_W  address to slave
//  s_wdata     out  DATA_W  write data to slave
//  s_rready    out  1       read ready to slave
//  s_wready    in   1       slave write complete
//  s_rvalid    in   1       slave read data valid
//  s_rdata     in   DATA_W  slave read data
//  gnt         out  2       one-hot current owner (bit N = master N); 00 when idle
//  mN_err      out  1       timeout abort pulse (exists only with BUS_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - States: IDLE, OWN0, OWN1. Registers: state, last_gnt (1 bit), and timeout counter when enabled.
//  - Reset: state=IDLE, last_gnt=1 (so master 0 wins the first tie). All outputs are 0.
//  - IDLE transitions:
//      only m0_valid -> OWN0; only m1_valid -> OWN1;
//      both valid -> the master != last_gnt; neither -> stay in IDLE.
//  - Latency: request sampled in IDLE at edge k; s_valid is high from cycle k+1. Grant latency = 1 cycle.
//  - OWNn outputs (combinational from state and inputs):
//      s_valid/s_mode/s_addr/s_wdata/s_rready = owner's signals.
//      owner mN_wready = s_wready; owner mN_rvalid = s_rvalid; owner mN_rdata = s_rdata.
//      Non-owner: wready=0, rvalid=0, rdata=0.
//  - In IDLE: s_* = 0, all mN_wready/rvalid = 0, all mN_rdata = 0.
//  - Completion:
//      write: s_mode=1 & s_wready. Read: s_mode=0 & s_rvalid & s_rready.
//      Next state IDLE; last_gnt <= owner.
//  - One-cycle idle bubble after every completion. Back-to-back requests from the same master alternate with the other master if it is waiting.
//  - Abandon: owner drops mN_valid before completion -> IDLE next cycle; last_gnt <= owner. The slave is expected to discard the request.
//  - Slave responses in IDLE are ignored and not forwarded.
//  - Non-owner requests are held off (no response) until they are granted. No starvation: max wait = one transaction + 2 cycles.
//  - Masters must keep mode/addr/wdata stable while valid. The arbiter does not latch them.
//  - Synchronous rst mid-transaction -> IDLE; outputs are 0 from the next cycle; the in-flight transaction is lost.
// CONFIGURATION
//  BUS_ARB_TIMEOUT_EN defined:
//    - Counter clears on entry to OWNn and increments each OWNn cycle.
//    - At count == TIMEOUT_CYCLES-1 without completion: pulse mN_err of the owner for 1 cycle, force IDLE, set last_gnt <= owner.
//    - Completion in the same cycle as timeout wins: no err.
//  BUS_ARB_TIMEOUT_EN undefined: no counter and no mN_err ports. A hung slave holds the grant indefinitely.
// TESTING
//  1. Reset: rst=1 for 2 cycles, with m0_valid=1 -> gnt=00, s_valid=0 during rst; gnt=01 on the 2nd cycle after rst falls.
//  2. m0 read of addr 0x100; slave s_rvalid=1, s_rdata=0xDEADBEEF after 3 cycles -> m0_rvalid=1 with that data, m1_rvalid=0, gnt=00 next cycle.
//  3. m0 and m1 both request writes continuously from reset -> grants alternate 01,00,10,00,01,..., each ending on s_wready; s_addr follows the owner.
//  4. m1 owns (read 0x40, slave silent); m1_valid drops -> IDLE next cycle; a waiting m0 is granted the cycle after.
//  5. rst asserted while OWN1 with s_valid=1 -> s_valid=0, gnt=00 next cycle; a late s_rvalid is not forwarded to either master.
//  6. BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds -> m0_err pulses once, in the 8th owned cycle; then IDLE; m1 is granted next if requesting.

Source files
------------

// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter for the shared CPU memory bus.
// Optional watchdog abort enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter2 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  input  logic              m0_mode,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_rready,
  output logic              m0_wready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_mode,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_rready,
  output logic              m1_wready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic              s_mode,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_rready,
  input  logic              s_wready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        gnt
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  output logic              m0_err,
  output logic              m1_err
`endif
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state, state_nx;
  logic   last_gnt, last_gnt_nx;
  logic   done0, done1;
  logic   timeout;

  // Completion as seen on the owner's request direction.
  assign done0 = m0_mode ? s_wready : (s_rvalid & m0_rready);
  assign done1 = m1_mode ? s_wready : (s_rvalid & m1_rready);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  // Counts owned cycles; IDLE clears it so every grant starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign timeout = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nx;
      last_gnt <= last_gnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    last_gnt_nx = last_gnt;
    gnt         = 2'b00;
    s_valid     = 1'b0;
    s_mode      = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_rready    = 1'b0;
    m0_wready   = 1'b0;
    m0_rvalid   = 1'b0;
    m0_rdata    = '0;
    m1_wready   = 1'b0;
    m1_rvalid   = 1'b0;
    m1_rdata    = '0;
`ifdef BUS_ARB_TIMEOUT_EN
    m0_err      = 1'b0;
    m1_err      = 1'b0;
`endif
    case (state)
      IDLE: begin
        // On a tie the master that did not own the bus last goes first.
        if (m0_valid && m1_valid) begin
          state_nx = last_gnt ? OWN0 : OWN1;
        end else if (m0_valid) begin
          state_nx = OWN0;
        end else if (m1_valid) begin
          state_nx = OWN1;
        end
      end
      OWN0: begin
        gnt       = 2'b01;
        s_valid   = m0_valid;
        s_mode    = m0_mode;
        s_addr    = m0_addr;
        s_wdata   = m0_wdata;
        s_rready  = m0_rready;
        m0_wready = s_wready;
        m0_rvalid = s_rvalid;
        m0_rdata  = s_rdata;
        if (!m0_valid || done0 || timeout) begin
          state_nx    = IDLE;
          last_gnt_nx = 1'b0;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        m0_err = timeout && m0_valid && !done0;
`endif
      end
      OWN1: begin
        gnt       = 2'b10;
        s_valid   = m1_valid;
        s_mode    = m1_mode;
        s_addr    = m1_addr;
        s_wdata   = m1_wdata;
        s_rready  = m1_rready;
        m1_wready = s_wready;
        m1_rvalid = s_rvalid;
        m1_rdata  = s_rdata;
        if (!m1_valid || done1 || timeout) begin
          state_nx    = IDLE;
          last_gnt_nx = 1'b1;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        m1_err = timeout && m1_valid && !done1;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed self-checking bench for bus_arbiter2; covers the BUS_ARB_TIMEOUT_EN
// build (TIMEOUT_CYCLES=8) when that macro is defined.
module tb_bus_arbiter2;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_valid, m0_mode, m0_rready, m0_wready, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_valid, m1_mode, m1_rready, m1_wready, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              s_valid, s_mode, s_rready, s_wready, s_rvalid;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, s_rdata;
  logic [1:0]        gnt;
`ifdef BUS_ARB_TIMEOUT_EN
  logic              m0_err, m1_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter2 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_mode(m0_mode), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rready(m0_rready), .m0_wready(m0_wready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_mode(m1_mode), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rready(m1_rready), .m1_wready(m1_wready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_mode(s_mode), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rready(s_rready), .s_wready(s_wready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .gnt(gnt)
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    .m0_err(m0_err), .m1_err(m1_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_valid = 1'b1; m0_mode = 1'b0; m0_addr = 32'h100; m0_wdata = '0; m0_rready = 1'b1;
    m1_valid = 1'b0; m1_mode = 1'b0; m1_addr = '0;     m1_wdata = '0; m1_rready = 1'b0;
    s_wready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;

    // Reset with m0 already requesting
    step(); #1;
    chk("rst1_gnt", 64'(gnt), 64'd0);
    chk("rst1_svalid", 64'(s_valid), 64'd0);
    step(); rst = 1'b0; #1;
    chk("rst2_gnt", 64'(gnt), 64'd0);
    chk("rst2_svalid", 64'(s_valid), 64'd0);
    step(); #1;
    chk("post_rst_gnt", 64'(gnt), 64'd1);
    chk("post_rst_svalid", 64'(s_valid), 64'd1);

    // m0 read of 0x100, data arrives in the 4th owned cycle
    chk("rd_saddr", 64'(s_addr), 64'h100);
    chk("rd_smode", 64'(s_mode), 64'd0);
    chk("rd_srready", 64'(s_rready), 64'd1);
    chk("rd_wait_rvalid", 64'(m0_rvalid), 64'd0);
    step(); step(); step();
    s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF; #1;
    chk("rd_m0_rvalid", 64'(m0_rvalid), 64'd1);
    chk("rd_m0_rdata", 64'(m0_rdata), 64'hDEADBEEF);
    chk("rd_m1_rvalid", 64'(m1_rvalid), 64'd0);
    chk("rd_m1_rdata", 64'(m1_rdata), 64'd0);
    step(); m0_valid = 1'b0; #1;
    chk("rd_done_gnt", 64'(gnt), 64'd0);
    chk("idle_ignore_rvalid", 64'(m0_rvalid), 64'd0);
    chk("idle_ignore_rdata", 64'(m0_rdata), 64'd0);
    s_rvalid = 1'b0; s_rdata = '0;

    // Both masters write continuously from reset; slave completes every cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    m0_valid = 1'b1; m0_mode = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hA0;
    m1_valid = 1'b1; m1_mode = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hB1;
    s_wready = 1'b1; #1;
    chk("wr_idle_gnt", 64'(gnt), 64'd0);
    chk("wr_idle_wready", 64'(m0_wready), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      case (i % 4)
        0: begin
          chk("wr_gnt0", 64'(gnt), 64'd1);
          chk("wr_saddr0", 64'(s_addr), 64'h10);
          chk("wr_swdata0", 64'(s_wdata), 64'hA0);
          chk("wr_m0_wready0", 64'(m0_wready), 64'd1);
          chk("wr_m1_wready0", 64'(m1_wready), 64'd0);
        end
        2: begin
          chk("wr_gnt1", 64'(gnt), 64'd2);
          chk("wr_saddr1", 64'(s_addr), 64'h20);
          chk("wr_swdata1", 64'(s_wdata), 64'hB1);
          chk("wr_m0_wready1", 64'(m0_wready), 64'd0);
          chk("wr_m1_wready1", 64'(m1_wready), 64'd1);
        end
        default: begin
          chk("wr_bubble_gnt", 64'(gnt), 64'd0);
          chk("wr_bubble_saddr", 64'(s_addr), 64'd0);
          chk("wr_bubble_svalid", 64'(s_valid), 64'd0);
        end
      endcase
    end

    // m1 owns a read of 0x40 with a silent slave, then abandons; m0 waits
    m0_valid = 1'b0; s_wready = 1'b0;
    m1_mode = 1'b0; m1_addr = 32'h40; m1_rready = 1'b1;
    step(); #1;
    chk("ab_gnt", 64'(gnt), 64'd2);
    chk("ab_saddr", 64'(s_addr), 64'h40);
    m0_valid = 1'b1; m0_mode = 1'b0; m0_addr = 32'h100; #1;
    chk("ab_hold_saddr", 64'(s_addr), 64'h40);
    step(); #1;
    chk("ab_still_gnt", 64'(gnt), 64'd2);
    m1_valid = 1'b0; #1;
    chk("ab_drop_svalid", 64'(s_valid), 64'd0);
    step(); #1;
    chk("ab_idle_gnt", 64'(gnt), 64'd0);
    step(); #1;
    chk("ab_m0_gnt", 64'(gnt), 64'd1);
    chk("ab_m0_saddr", 64'(s_addr), 64'h100);

    // Reset while m1 owns with s_valid high
    m0_valid = 1'b0;
    step();
    m1_valid = 1'b1; #1;
    chk("rs_idle_gnt", 64'(gnt), 64'd0);
    step(); #1;
    chk("rs_own1_gnt", 64'(gnt), 64'd2);
    chk("rs_own1_svalid", 64'(s_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; m1_valid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h12345678; #1;
    chk("rs_gnt", 64'(gnt), 64'd0);
    chk("rs_svalid", 64'(s_valid), 64'd0);
    chk("rs_m1_rvalid", 64'(m1_rvalid), 64'd0);
    chk("rs_m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("rs_m1_rdata", 64'(m1_rdata), 64'd0);

    // After reset a tie goes to m0
    step();
    s_rvalid = 1'b0; s_rdata = '0; m0_valid = 1'b1; m1_valid = 1'b1;
    step(); #1;
    chk("tie_gnt", 64'(gnt), 64'd1);

    // Slave never answers m0's read while m1 waits
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      chk("to_gnt", 64'(gnt), 64'd1);
      chk("to_m0_err", 64'(m0_err), (c == 8) ? 64'd1 : 64'd0);
      chk("to_m1_err", 64'(m1_err), 64'd0);
      step(); #1;
    end
    chk("to_idle_gnt", 64'(gnt), 64'd0);
    chk("to_idle_err", 64'(m0_err), 64'd0);
    step(); #1;
    chk("to_m1_gnt", 64'(gnt), 64'd2);
`else
    for (int c = 1; c <= 12; c++) begin
      chk("hang_gnt", 64'(gnt), 64'd1);
      chk("hang_m1_rvalid", 64'(m1_rvalid), 64'd0);
      step(); #1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
